// File: rtl/regfile_pkg.sv
// Register file constants and types shared by the write-back arbiter.
package regfile_pkg;

  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // One-hot mask selecting a single scoreboard bit.
  function automatic logic [NUM_REGS-1:0] reg_mask(input reg_addr_t addr);
    return NUM_REGS'(1) << addr;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter over NREQ requests. WB_RR_EN selects round robin with a rotating pointer;
// otherwise fixed priority with request 0 highest.
module rr_arbiter #(
  parameter int unsigned NREQ = 2
) (
`ifdef WB_RR_EN
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
`endif
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

`ifdef WB_RR_EN
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  // Search starts at the pointer; the pointer moves to one past the winner.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
        ptr_d      = (idx == int'(NREQ) - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ requesters via 1-entry buffers and keeps a
// pending-write scoreboard with issue hazards. WB_RR_EN selects round-robin arbitration.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned DATA_W = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ*ADDR_W-1:0]           req_rd,
  input  logic [NREQ*DATA_W-1:0]           req_data,
  output logic                             wr_en,
  output logic [ADDR_W-1:0]                wr_rd,
  output logic [DATA_W-1:0]                wr_data,
  output logic [NREQ-1:0]                  wr_grant,
  input  logic                             sb_set,
  input  logic [ADDR_W-1:0]                sb_set_rd,
  input  logic [ADDR_W-1:0]                iss_rs1,
  input  logic [ADDR_W-1:0]                iss_rs2,
  input  logic [ADDR_W-1:0]                iss_rd,
  output logic                             hazard,
  output logic [regfile_pkg::NUM_REGS-1:0] busy
);
  import regfile_pkg::*;

  logic [NREQ-1:0]   buf_v_q;
  logic [ADDR_W-1:0] buf_rd_q   [NREQ];
  logic [DATA_W-1:0] buf_data_q [NREQ];
  logic [NREQ-1:0]   load;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
`ifdef WB_RR_EN
    .clk     (clk),
    .rst     (rst),
    .advance (wr_en),
`endif
    .req     (buf_v_q),
    .grant   (wr_grant)
  );

  // A buffer being drained this cycle can take a new entry at the same edge.
  assign req_ready = ~buf_v_q | wr_grant;
  assign load      = req_valid & req_ready;
  assign wr_en     = |buf_v_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v_q <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        buf_rd_q[i]   <= '0;
        buf_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (load[i]) begin
          buf_v_q[i]    <= 1'b1;
          buf_rd_q[i]   <= req_rd[i*ADDR_W +: ADDR_W];
          buf_data_q[i] <= req_data[i*DATA_W +: DATA_W];
        end else if (wr_grant[i]) begin
          buf_v_q[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    wr_rd   = '0;
    wr_data = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (wr_grant[i]) begin
        wr_rd   |= buf_rd_q[i];
        wr_data |= buf_data_q[i];
      end
    end
  end

  // Set is applied after clear so an allocation wins over a retiring write to the same reg.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d &= ~reg_mask(wr_rd);
    end
    if (sb_set) begin
      busy_d |= reg_mask(sb_set_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign hazard = busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd];

endmodule
